// File: rtl/row_ptr_scheduler_pkg.sv
// Shared types and helpers for the row-pointer scheduler and its metadata FIFO.
package row_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WAIT_DEC
    } sched_state_t;

    localparam int unsigned META_PAR = 4;
    localparam int unsigned MASK_W   = 64;

    typedef struct packed {
        logic [META_PAR-1:0] mask;
        logic                last;
    } meta_t;

    // Contiguous lane mask from lane 0; callers narrow the result to their lane count.
    function automatic logic [MASK_W-1:0] len_to_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/row_ptr_scheduler_meta_fifo.sv
// Small synchronous FIFO holding per-request beat metadata (lane mask + last flag).
module row_ptr_meta_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == DEPTH_C);
        head    = mem_q[rd_ptr_q];
        do_pop  = pop && !empty;
        // A pop in the same cycle frees the slot the push is about to use.
        do_push = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
        if (do_push) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/row_ptr_scheduler.sv
// Issues chunked row-pointer reads under a credit limit and forwards responses
// to the row decoder as masked beats; reports job completion.
module row_ptr_scheduler
    import row_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = 32,
    parameter int unsigned PAR             = 4,
    parameter int unsigned ELEM_BYTES      = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [ADDR_WIDTH-1:0]     job_base,
    input  logic [ID_WIDTH-1:0]       job_rows,
    output logic                      rd_req_valid,
    input  logic                      rd_req_ready,
    output logic [ADDR_WIDTH-1:0]     rd_req_addr,
    output logic [$clog2(PAR):0]      rd_req_len,
    input  logic                      rd_rsp_valid,
    output logic                      rd_rsp_ready,
    input  logic [PAR*ID_WIDTH-1:0]   rd_rsp_data,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [PAR*ID_WIDTH-1:0]   dec_data,
    output logic [PAR-1:0]            dec_mask,
    output logic                      dec_last,
    input  logic                      dec_job_last,
    output logic                      busy,
    output logic                      done
);
    localparam int unsigned LEN_W = $clog2(PAR) + 1;
    localparam int unsigned CNT_W = ID_WIDTH + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [ADDR_WIDTH-1:0] STRIDE  = ADDR_WIDTH'(PAR * ELEM_BYTES);
    localparam logic [CNT_W-1:0]      PAR_CNT = CNT_W'(PAR);
    localparam logic [OUT_W-1:0]      OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [PAR-1:0] mask;
        logic           last;
    } dec_meta_t;

    sched_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic                  sticky_q, sticky_d;
    logic                  done_q, done_d;

    logic [LEN_W-1:0]      req_len;
    logic                  req_last, req_fire, dec_fire, job_fire;
    logic                  fifo_full, fifo_empty;
    dec_meta_t             push_meta, head_meta;

    row_ptr_meta_fifo #(
        .WIDTH (PAR + 1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_meta_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (push_meta),
        .pop       (dec_fire),
        .head      (head_meta),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        req_len        = (remaining_q >= PAR_CNT) ? LEN_W'(PAR) : remaining_q[LEN_W-1:0];
        req_last       = (remaining_q == CNT_W'(req_len));
        push_meta.mask = PAR'(len_to_mask(32'(req_len)));
        push_meta.last = req_last;

        job_ready    = (state_q == IDLE);
        busy         = (state_q != IDLE);
        done         = done_q;
        rd_req_valid = (state_q == ISSUE) && (outstanding_q < OUT_MAX) && !fifo_full;
        rd_req_addr  = addr_q;
        rd_req_len   = req_len;

        rd_rsp_ready = dec_ready && !fifo_empty;
        dec_valid    = rd_rsp_valid && !fifo_empty;
        dec_mask     = head_meta.mask;
        dec_last     = head_meta.last;
        for (int unsigned l = 0; l < PAR; l++) begin
            dec_data[l*ID_WIDTH +: ID_WIDTH] =
                head_meta.mask[l] ? rd_rsp_data[l*ID_WIDTH +: ID_WIDTH] : '0;
        end

        job_fire = job_valid && job_ready;
        req_fire = rd_req_valid && rd_req_ready;
        dec_fire = dec_valid && dec_ready;
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        sticky_d      = sticky_q;
        done_d        = 1'b0;
        outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(dec_fire);

        // An early decoder completion is remembered until the drain finishes.
        if (dec_job_last && (state_q == ISSUE || state_q == DRAIN)) sticky_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (job_fire) begin
                    addr_d      = job_base;
                    remaining_d = CNT_W'(job_rows) + CNT_W'(1);
                    if (job_rows == '0) done_d  = 1'b1;
                    else                state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (req_fire) begin
                    addr_d      = addr_q + STRIDE;
                    remaining_d = remaining_q - CNT_W'(req_len);
                    if (req_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dec_fire && head_meta.last) state_d = WAIT_DEC;
            end
            WAIT_DEC: begin
                if (dec_job_last || sticky_q) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    sticky_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            sticky_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            sticky_q      <= sticky_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: doc/row_ptr_scheduler.md
# row_ptr_scheduler

Job-level controller that sequences the CSR row-pointer stream into the row decoder. It accepts one job descriptor (row-pointer array base address and row count) and issues chunked row-pointer read requests to memory under an outstanding-request credit limit. It forwards in-order read responses as masked beats with `last` on the final beat, and signals job completion once the decoder reports its final row-id beat. It sits between the job/CSR front end, the memory read port and the row decoder input.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width.
- `ID_WIDTH`, 32, row-pointer entry width and row-count width.
- `PAR`, 4, row-pointer entries per beat; power of two, ≥2.
- `ELEM_BYTES`, 4, bytes per row-pointer entry.
- `MAX_OUTSTANDING`, 8, maximum requests issued but not yet forwarded; power of two, ≥1.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `job_valid`, in, 1: job descriptor valid.
- `job_ready`, out, 1: the block accepts a job.
- `job_base`, in, `ADDR_WIDTH`: byte address of `row_ptr[0]`.
- `job_rows`, in, `ID_WIDTH`: number of rows. The array holds `job_rows+1` entries.
- `rd_req_valid`, out, 1: read request valid.
- `rd_req_ready`, in, 1: read request accepted.
- `rd_req_addr`, out, `ADDR_WIDTH`: byte address of the request.
- `rd_req_len`, out, `$clog2(PAR)+1`: number of entries in the request, 1..PAR.
- `rd_rsp_valid`, in, 1: read response valid. Responses return in order.
- `rd_rsp_ready`, out, 1: read response accepted.
- `rd_rsp_data`, in, `PAR*ID_WIDTH`: response data; lane 0 is the lowest address.
- `dec_valid`, out, 1: beat valid to the decoder.
- `dec_ready`, in, 1: decoder accepts the beat.
- `dec_data`, out, `PAR*ID_WIDTH`: row-pointer lanes.
- `dec_mask`, out, `PAR`: lane-valid mask, contiguous from lane 0.
- `dec_last`, out, 1: final beat of the job.
- `dec_job_last`, in, 1: one-cycle pulse when the decoder hands off its final row-id beat of the job.
- `busy`, out, 1: a job is in flight.
- `done`, out, 1: one-cycle job-complete pulse.

## Operation
- State machine states: IDLE, ISSUE, DRAIN, WAIT_DEC.
- IDLE:
  - `job_ready=1`.
  - On a job handshake:
    - Latch `addr=job_base`.
    - Latch `remaining=job_rows+1`. The counter is `ID_WIDTH+1` bits, so `job_rows=2^ID_WIDTH-1` does not overflow.
    - If `job_rows==0`, stay in IDLE and pulse `done` next cycle; no request or beat is issued.
    - Otherwise go to ISSUE.
- ISSUE:
  - `rd_req_valid = (outstanding < MAX_OUTSTANDING)`.
  - `rd_req_len = min(PAR, remaining)`.
  - On a request handshake:
    - `addr += PAR*ELEM_BYTES`.
    - `remaining -= len`.
    - Push `{mask=(1<<len)-1, last=(remaining==len)}` into the metadata FIFO.
    - `outstanding++`.
  - After the handshake with `last=1`, go to DRAIN.
- Response path is combinational pass-through:
  - `dec_valid = rd_rsp_valid & meta_nonempty`.
  - `rd_rsp_ready = dec_ready & meta_nonempty`.
  - `dec_mask` and `dec_last` come from the FIFO head.
  - Unmasked `dec_data` lanes are driven 0.
  - On a decoder handshake: pop the FIFO and `outstanding--`.
  - A request handshake and a decoder handshake in the same cycle leave `outstanding` unchanged.
- DRAIN: when `outstanding==0` after the `dec_last` beat handshake, go to WAIT_DEC.
- WAIT_DEC: on `dec_job_last`, go to IDLE and pulse `done` next cycle.
- `dec_job_last` in any state other than WAIT_DEC is latched sticky and consumed on entry to WAIT_DEC. A pulse in IDLE is dropped.
- `busy = (state != IDLE)`.
- Responses arriving with an empty FIFO are never accepted (`rd_rsp_ready=0`).

## Timing
- Reset values: state IDLE, `outstanding=0`, FIFO empty, sticky flag 0.
  - `rd_req_valid=0`, `dec_valid=0`, `rd_rsp_ready=0`, `done=0`, `busy=0`.
  - `job_ready=1` whenever the state is IDLE, including during reset.
- Asserting `rst_n` low mid-job clears everything immediately, with no clock needed. In-flight responses are the memory side's responsibility.
- Job handshake in cycle 0 → first `rd_req_valid` in cycle 1.
- Requests are issued at most one per cycle, back-to-back with no bubbles while credits remain.
- Response → decoder beat: 0-cycle latency.
- `rd_req_*` holds stable while `rd_req_valid & !rd_req_ready`.
- `dec_*` follows `rd_rsp_*`; stability relies on the memory side holding its response.
- `done` is asserted exactly 1 cycle after the triggering event.
- The next job can be accepted in the cycle following `done`, since the state is already IDLE.

## Structure
- Package `row_sched_pkg`:
  - `sched_state_t` enum (IDLE, ISSUE, DRAIN, WAIT_DEC).
  - `meta_t` struct `{logic [PAR-1:0] mask; logic last;}`.
  - Function `len_to_mask`.
- Sub-module `row_ptr_meta_fifo`:
  - Synchronous FIFO with depth `MAX_OUTSTANDING` and width `PAR+1`.
  - Asynchronous active-low reset.
  - Outputs: `full`, `empty`, head data.
  - Simultaneous push and pop when full or empty are legal.

## Test plan
- PAR=4, `job_base=0x1000`, `job_rows=5` → requests (0x1000, len 4) and (0x1010, len 2). Beats `mask=4'b1111, last=0`, then `mask=4'b0011, last=1`, lanes 2–3 zero. `dec_job_last` → `done` 1 cycle later.
- `job_rows=3` → single request (base, len 4); single beat `mask=4'b1111, last=1`.
- `job_rows=0` → no `rd_req_valid` at all; `done` in cycle 1 after the handshake; `busy` stays 0.
- MAX_OUTSTANDING=2, `job_rows=15`, responses held off → `rd_req_valid` drops after 2 handshakes and reasserts the cycle after the first decoder handshake. Four beats total.
- `dec_ready` toggled 50% with simultaneous request and decoder handshakes → `outstanding` never exceeds 2, no beat lost or duplicated, data order preserved.
- `rst_n` pulsed low during ISSUE with 3 outstanding → outputs at reset values immediately. A fresh job with `job_rows=5` afterwards runs exactly as in the first scenario.
